// File: rtl/cfg_self_writer_pkg.sv
// Shared types and default constants for the configuration self-writer.
package cfg_self_writer_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_PRE_GAP    = 2;
    localparam int DEF_STROBE_LEN = 1;
    localparam int DEF_POST_GAP   = 2;
    localparam int DEF_MAX_WORDS  = 5285;
    localparam int DEF_MSB_FIRST  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_PRE,
        ST_STROBE,
        ST_POST,
        ST_DONE
    } state_t;

    // The gap timer is loaded with (length - 1), so it only needs to hold the largest length minus one.
    function automatic int gap_width(input int pre, input int len, input int post);
        int m;
        m = pre;
        if (len > m)  m = len;
        if (post > m) m = post;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cfg_self_writer_if.sv
// Byte-stream handshake between a bitstream source and the self-writer.
interface cfg_self_writer_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_last;

    modport master (output byte_data, output byte_valid, output byte_last, input byte_ready);
    modport slave  (input byte_data, input byte_valid, input byte_last, output byte_ready);
endinterface

// File: rtl/cfg_gap_timer.sv
// Loadable down-counter with a zero flag; times the PRE, STROBE and POST phases.
module cfg_gap_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/cfg_self_writer.sv
// Packs a byte stream into configuration words and issues a timed write strobe per word.
module cfg_self_writer
    import cfg_self_writer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PRE_GAP    = DEF_PRE_GAP,
    parameter int STROBE_LEN = DEF_STROBE_LEN,
    parameter int POST_GAP   = DEF_POST_GAP,
    parameter int MAX_WORDS  = DEF_MAX_WORDS,
    parameter int MSB_FIRST  = DEF_MSB_FIRST
) (
    input  logic                             CLK,
    input  logic                             rst,
    input  logic                             start,
    cfg_self_writer_if.slave                 bs,
    output logic [DATA_W-1:0]                SelfWriteData,
    output logic                             SelfWriteStrobe,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic [$clog2(MAX_WORDS+1)-1:0]   word_count
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int WC_W  = $clog2(MAX_WORDS + 1);
    localparam int TW    = gap_width(PRE_GAP, STROBE_LEN, POST_GAP);

    localparam logic [TW-1:0]    PRE_LOAD    = (PRE_GAP > 0)  ? TW'(PRE_GAP - 1)  : '0;
    localparam logic [TW-1:0]    STROBE_LOAD = TW'(STROBE_LEN - 1);
    localparam logic [TW-1:0]    POST_LOAD   = (POST_GAP > 0) ? TW'(POST_GAP - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NB - 1);
    localparam logic [WC_W-1:0]  MAX_WC      = WC_W'(MAX_WORDS);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] asm_reg, asm_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [DATA_W-1:0] word_base, word_new;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [WC_W-1:0]   wc_reg, wc_next, wc_inc;
    logic              last_reg, last_next;
    logic              finish_reg, finish_next;
    logic              ovf_reg, ovf_next;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]     tmr_value;
    logic              xfer, word_end, finish_now;

    cfg_gap_timer #(.W(TW)) u_gap_timer (
        .clk        (CLK),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    assign bs.byte_ready = (state_reg == ST_COLLECT);
    assign xfer          = bs.byte_valid && bs.byte_ready;
    assign word_end      = xfer && ((idx_reg == LAST_IDX) || bs.byte_last);
    assign wc_inc        = wc_reg + WC_W'(1);
    assign finish_now    = last_reg || (wc_inc == MAX_WC);

    // A fresh word starts from zero so a short final word leaves its unfilled lanes cleared.
    assign word_base = (idx_reg == '0) ? '0 : asm_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            localparam int POS = (MSB_FIRST != 0) ? (NB - 1 - gi) : gi;
            assign word_new[POS*8 +: 8] = (idx_reg == IDX_W'(gi)) ? bs.byte_data
                                                                  : word_base[POS*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        asm_next    = asm_reg;
        data_next   = data_reg;
        idx_next    = idx_reg;
        wc_next     = wc_reg;
        last_next   = last_reg;
        finish_next = finish_reg;
        ovf_next    = ovf_reg;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        tmr_value   = '0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next  = ST_COLLECT;
                    idx_next    = '0;
                    wc_next     = '0;
                    last_next   = 1'b0;
                    finish_next = 1'b0;
                    ovf_next    = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (xfer) begin
                    asm_next = word_new;
                    if (word_end) begin
                        data_next = word_new;
                        idx_next  = '0;
                        last_next = bs.byte_last;
                        tmr_load  = 1'b1;
                        if (PRE_GAP > 0) begin
                            state_next = ST_PRE;
                            tmr_value  = PRE_LOAD;
                        end else begin
                            state_next = ST_STROBE;
                            tmr_value  = STROBE_LOAD;
                        end
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            ST_PRE: begin
                if (tmr_zero) begin
                    state_next = ST_STROBE;
                    tmr_load   = 1'b1;
                    tmr_value  = STROBE_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_STROBE: begin
                if (tmr_zero) begin
                    wc_next = wc_inc;
                    // The end-of-session decision is taken here so a zero POST gap can exit directly.
                    if (POST_GAP > 0) begin
                        state_next  = ST_POST;
                        tmr_load    = 1'b1;
                        tmr_value   = POST_LOAD;
                        finish_next = finish_now;
                    end else if (finish_now) begin
                        state_next = ST_DONE;
                        ovf_next   = !last_reg;
                    end else begin
                        state_next = ST_COLLECT;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_POST: begin
                if (tmr_zero) begin
                    if (finish_reg) begin
                        state_next = ST_DONE;
                        ovf_next   = !last_reg;
                    end else begin
                        state_next = ST_COLLECT;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            asm_reg    <= '0;
            data_reg   <= '0;
            idx_reg    <= '0;
            wc_reg     <= '0;
            last_reg   <= 1'b0;
            finish_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            asm_reg    <= asm_next;
            data_reg   <= data_next;
            idx_reg    <= idx_next;
            wc_reg     <= wc_next;
            last_reg   <= last_next;
            finish_reg <= finish_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign SelfWriteData   = data_reg;
    assign SelfWriteStrobe = (state_reg == ST_STROBE);
    assign busy            = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done            = (state_reg == ST_DONE);
    assign overflow        = ovf_reg;
    assign word_count      = wc_reg;

endmodule

// File: doc/cfg_self_writer.md
CFG_SELF_WRITER -- requirements
Module: cfg_self_writer

Interface
REQ-001 Parameter DATA_W, default 32, SelfWriteData width; SHALL be a multiple of 8.
REQ-002 Parameter PRE_GAP, default 2, idle cycles between word-complete and strobe; 0 allowed.
REQ-003 Parameter STROBE_LEN, default 1, strobe high cycles; minimum 1.
REQ-004 Parameter POST_GAP, default 2, idle cycles after strobe before the next byte is accepted; 0 allowed.
REQ-005 Parameter MAX_WORDS, default 5285, word limit per session (21140 bytes / 4).
REQ-006 Parameter MSB_FIRST, default 1; 1 places the first byte in bits [DATA_W-1:DATA_W-8].
REQ-007 CLK  in  1  single clock; all logic on its rising edge.
REQ-008 rst  in  1  reset, synchronous and active-high.
REQ-009 start  in  1  one-cycle pulse that opens a load session.
REQ-010 byte_data  in  8  bitstream byte.
REQ-011 byte_valid / byte_ready  in / out  1 / 1  byte handshake; a transfer occurs when both are high.
REQ-012 byte_last  in  1  marks the final byte of the bitstream; sampled with the transfer.
REQ-013 SelfWriteData  out  DATA_W  packed configuration word.
REQ-014 SelfWriteStrobe  out  1  configuration write strobe.
REQ-015 busy, done, overflow  out  1 each  session status.
REQ-016 word_count  out  $clog2(MAX_WORDS+1)  number of words strobed this session.

Function
REQ-017 States and transitions:
- IDLE: start -> COLLECT.
- COLLECT: word complete -> PRE.
- PRE -> STROBE.
- STROBE -> POST.
- POST -> COLLECT, or DONE if the word carried byte_last or word_count==MAX_WORDS.
- DONE: start -> COLLECT.
REQ-018 Starting a session from IDLE or DONE clears word_count, done, overflow and the byte index.
REQ-019 byte_ready SHALL be high only in COLLECT.
REQ-020 A word is complete on the transfer of byte index DATA_W/8-1, or on any transfer with byte_last=1.
REQ-021 On a byte_last word, unfilled byte positions SHALL be zero.
REQ-022 If the final handshake occurs in cycle c:
- SelfWriteData is valid from c+1 and held stable until the next word completes.
- SelfWriteStrobe is high in cycles c+1+PRE_GAP .. c+PRE_GAP+STROBE_LEN.
- byte_ready returns in cycle c+1+PRE_GAP+STROBE_LEN+POST_GAP.
REQ-023 With PRE_GAP=0, the strobe SHALL rise in cycle c+1. With POST_GAP=0, COLLECT SHALL follow STROBE directly.
REQ-024 word_count SHALL increment once per word, in the last STROBE cycle.
REQ-025 busy SHALL be high in every state except IDLE and DONE.
REQ-026 done SHALL be high in DONE only.
REQ-027 If word_count reaches MAX_WORDS without byte_last having been seen, overflow SHALL be set in DONE and held until the next start.
REQ-028 start while busy SHALL be ignored.
REQ-029 byte_valid outside COLLECT SHALL be ignored, with no data loss assumed by the block.

Reset
REQ-030 rst, at any state including mid-STROBE, SHALL set on the next edge:
- state = IDLE;
- SelfWriteData = 0, SelfWriteStrobe = 0;
- byte_ready = 0, busy = 0, done = 0, overflow = 0;
- word_count = 0, byte index = 0, gap counter = 0.
REQ-031 rst SHALL take priority over start.

Structure
REQ-032 Package cfg_self_writer_pkg SHALL hold the state enum and the default parameter constants.
REQ-033 One sub-module, cfg_gap_timer, SHALL provide a loadable down-counter with a zero flag, shared by the PRE, STROBE and POST states.

Verification
REQ-034 Defaults; bytes 12,34,56,78 with byte_valid held high -> SelfWriteData=0x12345678; strobe high exactly at c+3; byte_ready back at c+6; word_count=1.
REQ-035 MSB_FIRST=0; same bytes -> SelfWriteData=0x78563412.
REQ-036 Bytes AB, CD with byte_last on CD -> SelfWriteData=0xABCD0000; one strobe; done=1; overflow=0; byte_ready stays 0.
REQ-037 MAX_WORDS=2; 12 bytes offered, byte_last never set -> exactly 2 strobes; overflow=1; done=1; only 8 bytes accepted.
REQ-038 rst asserted during the strobe cycle -> strobe=0 and all outputs at reset values on the next edge; a fresh start reloads correctly from word 0.
REQ-039 PRE_GAP=0, POST_GAP=0, STROBE_LEN=3; 8 bytes with byte_valid held high -> strobe high 3 cycles per word; 7-cycle word period; word_count=2.
